// File: rtl/imem_if.sv
// Fetch-stage instruction bus: request strobe and byte address out from the
// fetcher, acknowledge, instruction word, error flag and busy back from memory.
interface imem_if;
  logic        stb;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] inst;
  logic        err;
  logic        busy;

  modport master (output stb, output addr, input ack, input inst, input err, input busy);
  modport slave  (input stb, input addr, output ack, output inst, output err, output busy);
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-organised on-chip store answering fetch
// requests after a fixed number of wait states, with a side loader port.
module imem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  imem_if.slave                 bus,
  input  logic                  i_ld_we,
  input  logic [DEPTH_LOG2-1:0] i_ld_addr,
  input  logic [31:0]           i_ld_data
);

  localparam int unsigned WORDS    = 32'd1 << DEPTH_LOG2;
  localparam logic [63:0] LIMIT    = 64'd4 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 32'd1) ? 4'(LATENCY - 32'd2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [31:0]           r_addr;
  logic                  r_ack;
  logic                  r_err;
  logic [31:0]           r_inst;
  logic [31:0]           r_mem [0:WORDS-1];

  logic                  w_accept;
  logic [31:0]           w_req_addr;
  logic [31:0]           w_off;
  logic                  w_misal;
  logic                  w_oor;
  logic                  w_bad;
  logic [DEPTH_LOG2-1:0] w_index;

  // With LATENCY==1 the read happens at the accept edge, so decode the live
  // address in IDLE and the captured one otherwise.
  assign w_accept   = (r_state == S_IDLE) && bus.stb && !i_ld_we;
  assign w_req_addr = (r_state == S_IDLE) ? bus.addr : r_addr;
  assign w_off      = w_req_addr - BASE_ADDR;
  assign w_misal    = (w_req_addr[1:0] != 2'b00);
  assign w_oor      = ({32'd0, w_off} >= LIMIT);
  assign w_bad      = w_misal || w_oor;
  assign w_index    = w_off[DEPTH_LOG2+1:2];

  // Next-state and wait-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 32'd1) begin
            w_state_nxt = S_ACK;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!bus.stb) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter and captured-address registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr <= bus.addr;
      end
    end
  end

  // Response registers; memory is sampled only on the edge entering ACK
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_inst <= NOP_WORD;
    end else begin
      r_ack <= (w_state_nxt == S_ACK);
      if (w_state_nxt == S_ACK) begin
        if (w_bad) begin
          r_inst <= NOP_WORD;
          r_err  <= 1'b1;
        end else begin
          r_inst <= r_mem[w_index];
          r_err  <= 1'b0;
        end
      end else begin
        r_err <= 1'b0;
      end
    end
  end

  // Loader writes are independent of reset and FSM state
  always_ff @(posedge clk) begin
    if (i_ld_we) begin
      r_mem[i_ld_addr] <= i_ld_data;
    end
  end

  assign bus.ack  = r_ack;
  assign bus.err  = r_err;
  assign bus.inst = r_inst;
  assign bus.busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: three responders (LATENCY 1, 4, 3) share loader and reset;
// the stimulus pushes expected acks, a negedge monitor pops and compares them.
module tb_imem_responder;
  localparam int          DL  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] B4  = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stb = 1'b0;
  logic [31:0]   addr = 32'd0;
  logic          ld_we = 1'b0;
  logic [DL-1:0] ld_addr = '0;
  logic [31:0]   ld_data = 32'd0;
  int            sel = 0;
  int            lat = 1;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;

  typedef struct {
    int          c;
    logic [31:0] inst;
    logic        err;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  logic        m_ack, m_err, m_busy, stray;
  logic [31:0] m_inst;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_if b0 ();
  imem_if b1 ();
  imem_if b2 ();
  assign b0.stb  = stb && (sel == 0);
  assign b1.stb  = stb && (sel == 1);
  assign b2.stb  = stb && (sel == 2);
  assign b0.addr = addr;
  assign b1.addr = addr;
  assign b2.addr = addr;

  imem_responder #(.DEPTH_LOG2(DL), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_l1 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data));
  imem_responder #(.DEPTH_LOG2(DL), .LATENCY(4), .BASE_ADDR(B4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data));
  imem_responder #(.DEPTH_LOG2(DL), .LATENCY(3), .BASE_ADDR(32'h0000_0000)) u_l3 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data));

  always_comb begin
    case (sel)
      1:       begin m_ack = b1.ack; m_err = b1.err; m_busy = b1.busy; m_inst = b1.inst; end
      2:       begin m_ack = b2.ack; m_err = b2.err; m_busy = b2.busy; m_inst = b2.inst; end
      default: begin m_ack = b0.ack; m_err = b0.err; m_busy = b0.busy; m_inst = b0.inst; end
    endcase
    stray = (sel != 0 && b0.ack) || (sel != 1 && b1.ack) || (sel != 2 && b2.ack);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DL-1:0] idx, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = idx; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  // Issue one request and hold it until acked; optionally pulse the loader
  // ldoff cycles after accept, and scramble the address in the first WAIT cycle.
  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ee,
                       input int ldoff, input logic [DL-1:0] lda, input logic [31:0] ldd);
    int   n;
    exp_t e;
    stb = 1'b1; addr = a;
    e.c = cyc + lat; e.inst = ei; e.err = ee;
    q.push_back(e);
    n = 0;
    while (!m_ack && n < 40) begin
      ld_we = (n == ldoff); ld_addr = lda; ld_data = ldd;
      if (n == 1) addr = a ^ 32'h0000_0040;
      tick();
      n++;
    end
    ld_we = 1'b0; addr = a;
    if (!m_ack) begin
      checks++; errors++;
      $display("FAIL fetch_timeout addr=%h actual=no_ack required=ack", a);
    end
    tick();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (stray) begin
        checks++; errors++;
        $display("FAIL stray_ack sel=%0d actual=ack required=none", sel);
      end
      if (m_ack) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack inst=%h actual=ack required=none (cycle %0d)", m_inst, cyc);
        end else begin
          mon_e = q.pop_front();
          chk("ack_cycle", cyc, mon_e.c);
          chk("inst", m_inst, mon_e.inst);
          chk("err", {31'd0, m_err}, {31'd0, mon_e.err});
        end
      end else begin
        chk("err_without_ack", {31'd0, m_err}, 32'd0);
      end
    end
  end

  initial begin
    tick(); tick();
    chk("rst_ack_l1",  {31'd0, b0.ack},  32'd0);
    chk("rst_err_l1",  {31'd0, b0.err},  32'd0);
    chk("rst_inst_l1", b0.inst, NOP);
    chk("rst_busy_l1", {31'd0, b0.busy}, 32'd0);
    chk("rst_ack_l4",  {31'd0, b1.ack},  32'd0);
    chk("rst_err_l4",  {31'd0, b1.err},  32'd0);
    chk("rst_inst_l4", b1.inst, NOP);
    chk("rst_busy_l4", {31'd0, b1.busy}, 32'd0);
    chk("rst_ack_l3",  {31'd0, b2.ack},  32'd0);
    chk("rst_err_l3",  {31'd0, b2.err},  32'd0);
    chk("rst_inst_l3", b2.inst, NOP);
    chk("rst_busy_l3", {31'd0, b2.busy}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    load(4'd5, 32'hDEAD_BEEF);
    load(4'd0, 32'h0000_0001);
    load(4'd1, 32'h0000_0002);
    load(4'd2, 32'h0000_0003);
    load(4'd3, 32'h3333_3333);
    load(4'd4, 32'h0000_0004);

    // LATENCY 1: basic read, ack is a single pulse, back-to-back every 2 cycles
    sel = 0; lat = 1;
    fetch(32'd20, 32'hDEAD_BEEF, 1'b0, -1, '0, 32'd0);
    chk("ack_one_cycle", {31'd0, m_ack}, 32'd0);
    fetch(32'd0, 32'h0000_0001, 1'b0, -1, '0, 32'd0);
    fetch(32'd4, 32'h0000_0002, 1'b0, -1, '0, 32'd0);
    stb = 1'b0; tick();

    // LATENCY 4 with a non-zero base: streaming reads, then error cases
    sel = 1; lat = 4;
    fetch(B4,           32'h0000_0001, 1'b0, -1, '0, 32'd0);
    fetch(B4 + 32'd4,   32'h0000_0002, 1'b0, -1, '0, 32'd0);
    fetch(B4 + 32'd8,   32'h0000_0003, 1'b0, -1, '0, 32'd0);
    fetch(32'h0000_0002, NOP, 1'b1, -1, '0, 32'd0);
    fetch(B4 + 32'd64,  NOP, 1'b1, -1, '0, 32'd0);
    fetch(B4 - 32'd4,   NOP, 1'b1, -1, '0, 32'd0);
    fetch(B4 + 32'd6,   NOP, 1'b1, -1, '0, 32'd0);
    stb = 1'b0; tick();

    // LATENCY 3: abort after one WAIT cycle, then normal and loader-race reads
    sel = 2; lat = 3;
    stb = 1'b1; addr = 32'd0;
    tick(); tick();
    stb = 1'b0;
    chk("busy_in_wait", {31'd0, m_busy}, 32'd1);
    tick();
    chk("busy_after_abort", {31'd0, m_busy}, 32'd0);
    repeat (5) tick();
    fetch(32'd4,  32'h0000_0002, 1'b0, -1, '0, 32'd0);
    fetch(32'd12, 32'h3333_3333, 1'b0, 2, 4'd3, 32'h4444_4444);
    fetch(32'd12, 32'h4444_4444, 1'b0, -1, '0, 32'd0);
    fetch(32'd16, 32'h5555_5555, 1'b0, 1, 4'd4, 32'h5555_5555);
    stb = 1'b0; tick();

    // Loader beats a simultaneous IDLE strobe
    sel = 0; lat = 1;
    stb = 1'b1; addr = 32'd28; ld_we = 1'b1; ld_addr = 4'd7; ld_data = 32'hCAFE_F00D;
    tick();
    ld_we = 1'b0;
    chk("busy_loader_priority", {31'd0, m_busy}, 32'd0);
    fetch(32'd28, 32'hCAFE_F00D, 1'b0, -1, '0, 32'd0);
    stb = 1'b0; tick();

    // LATENCY 4: reset mid-WAIT discards the request, loader write still lands
    sel = 1; lat = 4;
    fetch(B4 + 32'd8, 32'h0000_0003, 1'b0, -1, '0, 32'd0);
    addr = B4 + 32'd4;
    tick(); tick();
    rst_n = 1'b0; ld_we = 1'b1; ld_addr = 4'd9; ld_data = 32'h9999_0009;
    tick();
    rst_n = 1'b1; ld_we = 1'b0; stb = 1'b0;
    chk("midrst_ack",  {31'd0, m_ack},  32'd0);
    chk("midrst_err",  {31'd0, m_err},  32'd0);
    chk("midrst_inst", m_inst, NOP);
    chk("midrst_busy", {31'd0, m_busy}, 32'd0);
    repeat (6) tick();
    fetch(B4 + 32'd36, 32'h9999_0009, 1'b0, -1, '0, 32'd0);
    stb = 1'b0;
    tick(); tick();

    chk("pending_expectations", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
